// File: rtl/pit_pkg.sv
// Shared types and constants for the Pending Interest Table.
// Holds the name/data widths, the control FSM state encoding and the
// table entry record used by pit_table and pit_cam_match.
package pit_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int BYTE_W   = 8;

  // Field widths of a stored entry. FACES on pit_table must equal FACES_W,
  // and LIFETIME must fit in TIMER_W bits (50000 needs 16).
  localparam int FACES_W  = 4;
  localparam int TIMER_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    INSERT,
    LOOKUP,
    TRANSFER
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [PREFIX_W-1:0] prefix;
    logic [LEN_W-1:0]    len;
    logic [FACES_W-1:0]  faces;
    logic [TIMER_W-1:0]  timer;
  } pit_entry_t;

  // Face index to face bitmap.
  function automatic logic [FACES_W-1:0] face_onehot(input logic [$clog2(FACES_W)-1:0] face);
    return FACES_W'(1) << face;
  endfunction

endpackage

// File: rtl/pit_cam_match.sv
// Combinational associative search over the PIT entry array.
// Ports:
//   entries     in   full entry array
//   key_prefix  in   prefix to look up
//   key_len     in   prefix length to look up
//   hit         out  some valid entry matches both prefix and length exactly
//   hit_idx     out  lowest matching index
//   free_found  out  at least one invalid entry exists
//   free_idx    out  lowest invalid index
module pit_cam_match
  import pit_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  pit_entry_t          entries [ENTRIES],
  input  logic [PREFIX_W-1:0] key_prefix,
  input  logic [LEN_W-1:0]    key_len,
  output logic                hit,
  output logic [IDX_W-1:0]    hit_idx,
  output logic                free_found,
  output logic [IDX_W-1:0]    free_idx
);

  // NOTE: every output gets a default before the loop so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    // Scan high to low so the lowest qualifying index is written last.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].prefix == key_prefix && entries[i].len == key_len) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!entries[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pit_table.sv
// Pending Interest Table. Records interests per prefix, aggregates
// duplicates into a face bitmap, asks the FIB to forward first-time
// interests, answers FIB data queries and streams the data bytes to the
// requesting faces before freeing the entry. Entries expire after LIFETIME.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   interest_valid/ready             interest handshake
//   interest_prefix/len/face         interest name, length and arrival face
//   interest_nack                    pulse: interest dropped, table full
//   fib_out_bit                      pulse: FIB forwarding request
//   pit_out_prefix/len               name sent with the request, then held
//   prefix_ready, fib_prefix/len     FIB data-path query
//   start_send_to_pit, rejected      query answer pulses
//   fib_data                         data byte stream from FIB
//   data_out/valid/faces/last        registered data stream to faces
//   timeout_evt                      pulse: one or more entries expired
//   busy                             FSM not in IDLE
module pit_table
  import pit_pkg::*;
#(
  parameter int ENTRIES    = 16,
  parameter int FACES      = FACES_W,
  parameter int LIFETIME   = 50000,
  parameter int DATA_BYTES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       interest_valid,
  output logic                       interest_ready,
  input  logic [PREFIX_W-1:0]        interest_prefix,
  input  logic [LEN_W-1:0]           interest_len,
  input  logic [$clog2(FACES)-1:0]   interest_face,
  output logic                       interest_nack,
  output logic                       fib_out_bit,
  output logic [PREFIX_W-1:0]        pit_out_prefix,
  output logic [LEN_W-1:0]           pit_out_len,
  input  logic                       prefix_ready,
  input  logic [PREFIX_W-1:0]        fib_prefix,
  input  logic [LEN_W-1:0]           fib_len,
  output logic                       start_send_to_pit,
  output logic                       rejected,
  input  logic [BYTE_W-1:0]          fib_data,
  output logic [BYTE_W-1:0]          data_out,
  output logic                       data_out_valid,
  output logic [FACES-1:0]           data_out_faces,
  output logic                       data_last,
  output logic                       timeout_evt,
  output logic                       busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(DATA_BYTES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LIFETIME);
  localparam logic [CNT_W-1:0]   LAST_BYTE  = CNT_W'(DATA_BYTES - 1);

  state_t state_q, state_d;

  pit_entry_t entries_q [ENTRIES];
  pit_entry_t entries_d [ENTRIES];

  logic                     alive_q;
  logic [PREFIX_W-1:0]      int_prefix_q, qry_prefix_q, key_prefix, pit_out_prefix_q;
  logic [LEN_W-1:0]         int_len_q, qry_len_q, key_len, pit_out_len_q;
  logic [$clog2(FACES)-1:0] int_face_q;
  logic [IDX_W-1:0]         xfer_idx_q;
  logic [CNT_W-1:0]         byte_cnt_q;

  logic             cam_hit, cam_free_found;
  logic [IDX_W-1:0] cam_hit_idx, cam_free_idx;
  logic             accept_int, ins_hit, ins_new, ins_full, lkp_hit, xfer_last;

  // The single CAM sees the FIB query while in LOOKUP, the interest otherwise.
  assign key_prefix = (state_q == LOOKUP) ? qry_prefix_q : int_prefix_q;
  assign key_len    = (state_q == LOOKUP) ? qry_len_q    : int_len_q;

  pit_cam_match #(.ENTRIES(ENTRIES)) u_cam (
    .entries    (entries_q),
    .key_prefix (key_prefix),
    .key_len    (key_len),
    .hit        (cam_hit),
    .hit_idx    (cam_hit_idx),
    .free_found (cam_free_found),
    .free_idx   (cam_free_idx)
  );

  assign ins_hit   = (state_q == INSERT) && cam_hit;
  assign ins_new   = (state_q == INSERT) && !cam_hit && cam_free_found;
  assign ins_full  = (state_q == INSERT) && !cam_hit && !cam_free_found;
  assign lkp_hit   = (state_q == LOOKUP) && cam_hit;
  assign xfer_last = (state_q == TRANSFER) && (byte_cnt_q == LAST_BYTE);

  // alive_q keeps interest_ready low while reset is asserted and for the
  // first cycle after release, so every output reads 0 under reset.
  assign interest_ready = alive_q && (state_q == IDLE) && !prefix_ready;
  assign accept_int     = interest_valid && interest_ready;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (prefix_ready)    state_d = LOOKUP;
        else if (accept_int) state_d = INSERT;
      end
      INSERT:   state_d = IDLE;
      LOOKUP:   state_d = cam_hit ? TRANSFER : IDLE;
      TRANSFER: if (xfer_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy              = (state_q != IDLE);
    fib_out_bit       = ins_new;
    interest_nack     = ins_full;
    start_send_to_pit = lkp_hit;
    rejected          = (state_q == LOOKUP) && !cam_hit;
    // The request name is valid alongside the fib_out_bit pulse and held after.
    pit_out_prefix    = ins_new ? int_prefix_q : pit_out_prefix_q;
    pit_out_len       = ins_new ? int_len_q    : pit_out_len_q;
  end

  // ---------------- Table update and ageing ----------------
  always_comb begin
    entries_d   = entries_q;
    timeout_evt = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      // Frozen: the entry being streamed, and the hit entry of INSERT or
      // LOOKUP (refreshed this cycle, or about to be latched for transfer).
      if (entries_q[i].valid &&
          !(((state_q == TRANSFER) && xfer_idx_q == IDX_W'(i)) ||
            ((ins_hit || lkp_hit) && cam_hit_idx == IDX_W'(i)))) begin
        entries_d[i].timer = entries_q[i].timer - TIMER_W'(1);
        if (entries_q[i].timer == TIMER_W'(1)) begin
          entries_d[i].valid = 1'b0;
          timeout_evt        = 1'b1;
        end
      end
    end
    // A miss searches the pre-expiry table, so a slot expiring this cycle
    // still looks occupied and cannot be claimed.
    if (ins_hit) begin
      entries_d[cam_hit_idx].faces = entries_q[cam_hit_idx].faces | face_onehot(int_face_q);
      entries_d[cam_hit_idx].timer = TIMER_LOAD;
    end else if (ins_new) begin
      entries_d[cam_free_idx].valid  = 1'b1;
      entries_d[cam_free_idx].prefix = int_prefix_q;
      entries_d[cam_free_idx].len    = int_len_q;
      entries_d[cam_free_idx].faces  = face_onehot(int_face_q);
      entries_d[cam_free_idx].timer  = TIMER_LOAD;
    end
    if (xfer_last) entries_d[xfer_idx_q].valid = 1'b0;
  end

  // NOTE: the table is a small flop array, so it is cleared entirely on
  // reset; a RAM-backed table would only clear the valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) entries_q <= '{default: '0};
    else      entries_q <= entries_d;
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_q          <= 1'b0;
      int_prefix_q     <= '0;
      int_len_q        <= '0;
      int_face_q       <= '0;
      qry_prefix_q     <= '0;
      qry_len_q        <= '0;
      pit_out_prefix_q <= '0;
      pit_out_len_q    <= '0;
      xfer_idx_q       <= '0;
      byte_cnt_q       <= '0;
      data_out         <= '0;
      data_out_valid   <= 1'b0;
      data_out_faces   <= '0;
      data_last        <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (state_q == IDLE) begin
        if (prefix_ready) begin
          qry_prefix_q <= fib_prefix;
          qry_len_q    <= fib_len;
        end else if (accept_int) begin
          int_prefix_q <= interest_prefix;
          int_len_q    <= interest_len;
          int_face_q   <= interest_face;
        end
      end
      if (ins_new) begin
        pit_out_prefix_q <= int_prefix_q;
        pit_out_len_q    <= int_len_q;
      end
      if (lkp_hit) begin
        xfer_idx_q     <= cam_hit_idx;
        data_out_faces <= entries_q[cam_hit_idx].faces;
        byte_cnt_q     <= '0;
      end
      data_out_valid <= (state_q == TRANSFER);
      data_last      <= xfer_last;
      if (state_q == TRANSFER) begin
        data_out   <= fib_data;
        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pit_table.sv
// Self-checking bench for pit_table: directed sequences plus a table of
// interest vectors. A second instance with LIFETIME=10 covers expiry.
module tb_pit_table;
  import pit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        interest_valid, interest_ready, interest_nack, fib_out_bit;
  logic [63:0] interest_prefix, pit_out_prefix, fib_prefix;
  logic [5:0]  interest_len, pit_out_len, fib_len;
  logic [1:0]  interest_face;
  logic        prefix_ready, start_send_to_pit, rejected;
  logic [7:0]  fib_data, data_out;
  logic        data_out_valid, data_last, timeout_evt, busy;
  logic [3:0]  data_out_faces;

  // Short-lifetime instance
  logic        s_interest_valid, s_interest_ready, s_interest_nack, s_fib_out_bit;
  logic [63:0] s_interest_prefix, s_pit_out_prefix, s_fib_prefix;
  logic [5:0]  s_interest_len, s_pit_out_len, s_fib_len;
  logic [1:0]  s_interest_face;
  logic        s_prefix_ready, s_start_send_to_pit, s_rejected;
  logic [7:0]  s_fib_data, s_data_out;
  logic        s_data_out_valid, s_data_last, s_timeout_evt, s_busy;
  logic [3:0]  s_data_out_faces;

  pit_table dut (
    .clk(clk), .rst(rst),
    .interest_valid(interest_valid), .interest_ready(interest_ready),
    .interest_prefix(interest_prefix), .interest_len(interest_len),
    .interest_face(interest_face), .interest_nack(interest_nack),
    .fib_out_bit(fib_out_bit), .pit_out_prefix(pit_out_prefix), .pit_out_len(pit_out_len),
    .prefix_ready(prefix_ready), .fib_prefix(fib_prefix), .fib_len(fib_len),
    .start_send_to_pit(start_send_to_pit), .rejected(rejected),
    .fib_data(fib_data), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_faces(data_out_faces), .data_last(data_last),
    .timeout_evt(timeout_evt), .busy(busy)
  );

  pit_table #(.LIFETIME(10)) dut_s (
    .clk(clk), .rst(rst),
    .interest_valid(s_interest_valid), .interest_ready(s_interest_ready),
    .interest_prefix(s_interest_prefix), .interest_len(s_interest_len),
    .interest_face(s_interest_face), .interest_nack(s_interest_nack),
    .fib_out_bit(s_fib_out_bit), .pit_out_prefix(s_pit_out_prefix), .pit_out_len(s_pit_out_len),
    .prefix_ready(s_prefix_ready), .fib_prefix(s_fib_prefix), .fib_len(s_fib_len),
    .start_send_to_pit(s_start_send_to_pit), .rejected(s_rejected),
    .fib_data(s_fib_data), .data_out(s_data_out), .data_out_valid(s_data_out_valid),
    .data_out_faces(s_data_out_faces), .data_last(s_data_last),
    .timeout_evt(s_timeout_evt), .busy(s_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  typedef struct {
    logic [63:0] prefix;
    logic [5:0]  len;
    logic [1:0]  face;
    logic        exp_fib;
    logic        exp_nack;
  } vec_t;

  localparam logic [63:0] P_A   = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] P_B   = 64'h0000_0000_BEEF_0002;
  localparam logic [63:0] P_UNK = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] P_S   = 64'h5555_0000_0000_0005;
  localparam logic [63:0] P_BASE = 64'h1000_0000_0000_0000;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [19];
    logic [63:0] exp_pit_prefix;
    logic [5:0]  exp_pit_len;
    int          bad, first, pulses;

    // Vector table: one duplicate of P_B, 15 new prefixes filling the
    // table, a 17th new prefix, a duplicate while full, and a length-only
    // mismatch while full.
    vecs[0] = '{P_B, 6'd12, 2'd3, 1'b0, 1'b0};
    for (int i = 1; i <= 15; i++)
      vecs[i] = '{P_BASE + 64'(i), 6'd32, 2'(i), 1'b1, 1'b0};
    vecs[16] = '{P_BASE + 64'd16, 6'd32, 2'd0, 1'b0, 1'b1};
    vecs[17] = '{P_BASE + 64'd3,  6'd32, 2'd1, 1'b0, 1'b0};
    vecs[18] = '{P_BASE + 64'd1,  6'd33, 2'd0, 1'b0, 1'b1};

    rst = 1'b0;
    interest_valid = 0; interest_prefix = '0; interest_len = '0; interest_face = '0;
    prefix_ready = 0; fib_prefix = '0; fib_len = '0; fib_data = '0;
    s_interest_valid = 0; s_interest_prefix = '0; s_interest_len = '0; s_interest_face = '0;
    s_prefix_ready = 0; s_fib_prefix = '0; s_fib_len = '0; s_fib_data = '0;

    // ---------------- reset state ----------------
    settle();
    check("rst_interest_ready", interest_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pit_out_prefix", pit_out_prefix, 0);
    check("rst_data_out_faces", data_out_faces, 0);
    check("rst_pulses", {fib_out_bit, interest_nack, start_send_to_pit, rejected, timeout_evt, data_out_valid, data_last}, 0);
    tick(); rst = 1'b1;
    tick();
    settle();
    check("idle_interest_ready", interest_ready, 1);

    // ---------------- expiry (LIFETIME=10 instance) ----------------
    tick(); s_interest_valid = 1; s_interest_prefix = P_S; s_interest_len = 6'd8; s_interest_face = 2'd0;
    settle(); check("s_ready", s_interest_ready, 1);
    tick(); s_interest_valid = 0;
    settle(); check("s_first_fib", s_fib_out_bit, 1);
    first = -1; pulses = 0;
    for (int c = 1; c <= 14; c++) begin
      tick(); settle();
      if (s_timeout_evt) begin pulses++; if (first < 0) first = c; end
    end
    check("s_timeout_cycle", 64'(first), 64'd10);
    check("s_timeout_pulses", 64'(pulses), 64'd1);
    // Expired entry is gone: same prefix is a first-time interest again.
    tick(); s_interest_valid = 1;
    tick(); s_interest_valid = 0;
    settle(); check("s_reuse_after_expiry_fib", s_fib_out_bit, 1);
    // Duplicate arriving exactly in the expiry cycle refreshes the entry.
    first = -1; pulses = 0;
    for (int c = 1; c <= 24; c++) begin
      tick(); s_interest_valid = (c == 9);
      settle();
      if (c == 10) check("s_refresh_no_fib", s_fib_out_bit, 0);
      if (s_timeout_evt) begin pulses++; if (first < 0) first = c; end
    end
    check("s_refresh_timeout_cycle", 64'(first), 64'd20);
    check("s_refresh_pulses", 64'(pulses), 64'd1);

    // ---------------- first interest ----------------
    tick(); interest_valid = 1; interest_prefix = P_A; interest_len = 6'd20; interest_face = 2'd1;
    settle(); check("a_ready", interest_ready, 1);
    tick(); interest_valid = 0;
    settle();
    check("a_fib_out_bit", fib_out_bit, 1);
    check("a_pit_out_prefix", pit_out_prefix, P_A);
    check("a_pit_out_len", pit_out_len, 20);
    check("a_nack", interest_nack, 0);
    check("a_insert_busy", busy, 1);
    tick(); settle();
    check("a_faces", dut.entries_q[0].faces, 4'b0010);
    check("a_fib_pulse_end", fib_out_bit, 0);
    check("a_pit_out_held", pit_out_prefix, P_A);

    // ---------------- duplicate from face 3 ----------------
    tick(); interest_valid = 1; interest_face = 2'd3;
    tick(); interest_valid = 0;
    settle(); check("a_dup_no_fib", fib_out_bit, 0);
    tick(); settle();
    check("a_dup_faces", dut.entries_q[0].faces, 4'b1010);

    // ---------------- query hit and transfer ----------------
    tick(); prefix_ready = 1; fib_prefix = P_A; fib_len = 6'd20;
    settle(); check("query_blocks_interest", interest_ready, 0);
    tick(); prefix_ready = 0;
    settle();
    check("a_start_send", start_send_to_pit, 1);
    check("a_not_rejected", rejected, 0);
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      tick();
      fib_data = 8'(k);
      prefix_ready = (k == 10);
      interest_valid = (k == 10);
      interest_prefix = P_UNK;
      settle();
      if (k == 0) check("xfer_no_early_valid", data_out_valid, 0);
      if (k == 10) check("xfer_interest_ready", interest_ready, 0);
      if (k > 0 && (data_out_valid !== 1'b1 || data_out !== 8'(k - 1) || data_last !== 1'b0))
        bad++;
      if (data_out_faces !== 4'b1010 || start_send_to_pit || rejected) bad++;
    end
    check("xfer_stream_errors", 64'(bad), 0);
    tick(); fib_data = 8'h00; prefix_ready = 0; interest_valid = 0;
    settle();
    check("xfer_last_byte", data_out, 8'hFF);
    check("xfer_last_valid", data_out_valid, 1);
    check("xfer_data_last", data_last, 1);
    check("xfer_idle", busy, 0);
    check("xfer_entry_freed", dut.entries_q[0].valid, 0);
    tick(); settle();
    check("xfer_valid_drops", {data_out_valid, data_last}, 0);
    tick(); prefix_ready = 1; fib_prefix = P_A; fib_len = 6'd20;
    tick(); prefix_ready = 0;
    settle(); check("a_query_after_free", rejected, 1);

    // ---------------- unknown query with simultaneous interest ----------------
    tick();
    prefix_ready = 1; fib_prefix = P_UNK; fib_len = 6'd5;
    interest_valid = 1; interest_prefix = P_B; interest_len = 6'd12; interest_face = 2'd2;
    settle(); check("both_interest_ready", interest_ready, 0);
    tick(); prefix_ready = 0;
    settle();
    check("unk_rejected", rejected, 1);
    check("unk_no_start", start_send_to_pit, 0);
    check("unk_lookup_ready", interest_ready, 0);
    tick(); settle();
    check("unk_back_idle_ready", interest_ready, 1);
    check("unk_no_data", data_out_valid, 0);
    tick(); interest_valid = 0;
    settle();
    check("b_fib_out_bit", fib_out_bit, 1);
    check("b_pit_out_prefix", pit_out_prefix, P_B);
    exp_pit_prefix = P_B;
    exp_pit_len    = 6'd12;

    // ---------------- vector table: aggregation and fill ----------------
    for (int v = 0; v < 19; v++) begin
      tick();
      interest_valid = 1; interest_prefix = vecs[v].prefix;
      interest_len = vecs[v].len; interest_face = vecs[v].face;
      settle(); check($sformatf("vec%0d_ready", v), interest_ready, 1);
      tick(); interest_valid = 0;
      settle();
      if (vecs[v].exp_fib) begin
        exp_pit_prefix = vecs[v].prefix;
        exp_pit_len    = vecs[v].len;
      end
      check($sformatf("vec%0d_fib", v), fib_out_bit, vecs[v].exp_fib);
      check($sformatf("vec%0d_nack", v), interest_nack, vecs[v].exp_nack);
      check($sformatf("vec%0d_pit_prefix", v), pit_out_prefix, exp_pit_prefix);
      check($sformatf("vec%0d_pit_len", v), pit_out_len, exp_pit_len);
    end

    // ---------------- reset in the middle of a transfer ----------------
    tick(); prefix_ready = 1; fib_prefix = P_BASE + 64'd1; fib_len = 6'd32;
    tick(); prefix_ready = 0;
    settle();
    check("r_start_send", start_send_to_pit, 1);
    check("r_faces_next", 64'(1), 64'(1));
    for (int k = 0; k <= 500; k++) begin
      tick(); fib_data = 8'(k);
    end
    check("r_pre_reset_byte", {data_out_valid, data_out}, {1'b1, 8'(499)});
    #1 rst = 1'b0;
    #1;
    check("r_reset_stream", {data_out_valid, data_last, data_out}, 0);
    check("r_reset_faces", data_out_faces, 0);
    check("r_reset_busy", busy, 0);
    check("r_reset_pit_out", {pit_out_prefix, 2'b00}, 0);
    check("r_reset_ready", interest_ready, 0);
    tick(); rst = 1'b1;
    bad = 0;
    for (int k = 501; k < 506; k++) begin
      tick(); fib_data = 8'(k);
      settle();
      if (data_out_valid || busy) bad++;
    end
    check("r_bytes_ignored", 64'(bad), 0);
    tick(); prefix_ready = 1; fib_prefix = P_BASE + 64'd1; fib_len = 6'd32;
    tick(); prefix_ready = 0;
    settle();
    check("r_query_rejected", rejected, 1);
    check("r_query_no_start", start_send_to_pit, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pit_table.md
Name: pit_table

Overview:
- Pending Interest Table for the NDN router. It sits directly beside the FIB table.
- Records incoming interests per prefix and aggregates duplicate requests by face bitmap.
- Forwards first-time interests to the FIB via fib_out_bit.
- Answers the FIB's data-path query with start_send_to_pit or rejected, then streams the accepted data bytes to the requesting faces and frees the entry.

Parameters:
ENTRIES, 16, number of PIT entries (power of 2)
FACES, 4, number of faces; width of face bitmap
LIFETIME, 50000, interest lifetime in clk cycles
DATA_BYTES, 1024, bytes per data packet transferred from FIB

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
interest_valid  in  1  interest present on interest_* inputs
interest_ready  out  1  interest accepted this cycle when high with interest_valid
interest_prefix  in  64  interest name prefix
interest_len  in  6  interest prefix length
interest_face  in  $clog2(FACES)  arrival face index
interest_nack  out  1  1-cycle pulse: interest dropped, table full
fib_out_bit  out  1  1-cycle pulse: request FIB forwarding
pit_out_prefix  out  64  prefix to FIB, held until next request
pit_out_len  out  6  length to FIB, held until next request
prefix_ready  in  1  FIB data-path query strobe (1 cycle)
fib_prefix  in  64  data prefix from FIB
fib_len  in  6  data length from FIB
start_send_to_pit  out  1  1-cycle pulse: match found, FIB may transfer
rejected  out  1  1-cycle pulse: no matching entry
fib_data  in  8  data byte from FIB
data_out  out  8  registered data byte to faces
data_out_valid  out  1  data_out qualifier
data_out_faces  out  FACES  destination face bitmap, stable during transfer
data_last  out  1  high with final data_out byte
timeout_evt  out  1  1-cycle pulse: an entry expired
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - all entries invalid and FSM to IDLE.
  - every output is 0, including pit_out_prefix/len and data_out_faces.
  - reset mid-transfer aborts the transfer; remaining FIB bytes are ignored.
- Entry contents: valid, prefix[63:0], len[5:0], faces[FACES-1:0], timer[$clog2(LIFETIME+1)-1:0].
- Match rule: valid and both len and the full 64-bit prefix are exactly equal.
- Free slot: the lowest-index invalid entry.
- interest_ready = (state==IDLE) && !prefix_ready. A FIB query therefore has priority over an interest in the same cycle.
- FSM states:
  - IDLE:
    - prefix_ready → LOOKUP, latching fib_prefix/fib_len.
    - Otherwise an accepted interest → INSERT, latching the interest.
  - INSERT (1 cycle), then IDLE:
    - hit: OR the face bit into faces and reload timer = LIFETIME; no FIB request.
    - miss with a free slot: write the entry with faces = one-hot(face) and timer = LIFETIME; pulse fib_out_bit and load pit_out_prefix/len in the same cycle.
    - miss with the table full: pulse interest_nack; table unchanged.
  - LOOKUP (1 cycle):
    - hit: pulse start_send_to_pit, latch the hit index and data_out_faces, clear the byte counter → TRANSFER.
    - miss: pulse rejected → IDLE.
    - The response occurs exactly one cycle after the prefix_ready cycle.
  - TRANSFER:
    - fib_data is sampled on DATA_BYTES consecutive cycles, starting the cycle after the start_send_to_pit pulse.
    - Each sample appears on data_out with data_out_valid one cycle later.
    - data_last accompanies byte DATA_BYTES-1.
    - The counter is $clog2(DATA_BYTES)+1 bits wide.
    - On the cycle the last byte is sampled, the entry is invalidated and the FSM returns to IDLE.
    - prefix_ready during TRANSFER is ignored.
- Timers:
  - Every valid entry decrements by 1 per cycle, except the entry latched for TRANSFER and an entry being written in INSERT that cycle.
  - When an entry would decrement from 1 to 0 it is invalidated and timeout_evt pulses; simultaneous expiries produce a single pulse.
  - An INSERT hit on an entry in its expiry cycle refreshes the entry; the refresh wins over the expiry.
  - An INSERT miss in that cycle cannot use the slot freed by the expiry.
- Interests never stall beyond TRANSFER; interest_ready stays low for the whole transfer.

Decomposition:
- pit_pkg holds:
  - constants: PREFIX_W=64, LEN_W=6, BYTE_W=8.
  - the FSM state enum: IDLE, INSERT, LOOKUP, TRANSFER.
  - the pit_entry_t struct (valid, prefix, len, faces, timer).
- Sub-module pit_cam_match: combinational.
  - Inputs: the entry array and a key (prefix, len).
  - Outputs: hit, hit_idx (lowest matching index), free_found, free_idx (lowest invalid index).
  - Instantiated once; its key input is muxed between the latched interest and the latched FIB query.

Test Plan:
- Interest prefix=0xA5A5_0000_0000_0001, len=20, face=1 into an empty table → fib_out_bit pulse in the INSERT cycle, pit_out_prefix=0xA5A5_0000_0000_0001, pit_out_len=20, entry 0 faces=4'b0010.
- Same prefix/len again from face 3 → no fib_out_bit, entry 0 faces=4'b1010. Then prefix_ready with that prefix → start_send_to_pit 1 cycle later. Drive bytes 0..1023 mod 256 → data_out matches with 1-cycle lag, data_out_faces=4'b1010, data_last on byte 1023, entry 0 freed afterwards.
- prefix_ready with an unknown prefix (len=5) → rejected pulse 1 cycle later, no data_out_valid, FSM back in IDLE.
- Fill 16 distinct prefixes, then a 17th → interest_nack pulse, no fib_out_bit. With LIFETIME=10 in a separate run: one entry left idle → timeout_evt exactly 10 cycles after its INSERT cycle, after which its slot is reusable.
- interest_valid and prefix_ready asserted in the same cycle → interest_ready=0, LOOKUP is serviced first, the interest is accepted after the FSM returns to IDLE.
- rst driven low at byte 500 of a transfer → all outputs 0 immediately. After release, the same prefix query gets rejected.
